// File: rtl/grn_io_pkg.sv
// Shared definitions for the output-side I/O controllers: FSM states,
// default data width and counter width.
package grn_io_pkg;

    localparam int unsigned DATA_W_DEF = 512;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [2:0] {
        FSM_IDLE   = 3'd0,
        FSM_WR_GAP = 3'd1,
        FSM_DONE   = 3'd2
    } fsm_state_t;

endpackage

// File: rtl/sync_fifo_buf.sv
// Small synchronous FIFO with async-reset pointers; the extra pointer MSB
// separates full from empty when the index bits match.
module sync_fifo_buf #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_one;

    assign w_one = {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + w_one;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + w_one;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/control_data_out.sv
// Output write controller: buffers core results and drains num_data_out words
// into the external output FIFO. Define CONTROL_DATA_OUT_STALL_CNT_EN for stall_cycles.
module control_data_out
    import grn_io_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_data_out,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    input  logic              available_write,
    output logic              wr_request_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              done
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cont_in;
    logic [CNT_W-1:0]  r_cont_wr;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_in_left;
    logic              w_wr_left;

    assign w_in_left = (r_cont_in < num_data_out);
    assign w_wr_left = (r_cont_wr < num_data_out);
    // Registered full only: a pop in the same cycle does not free a slot for a push.
    assign ready     = start & ~w_full & w_in_left;
    assign w_push    = data_in_valid & ready;

    sync_fifo_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FSM_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (start) begin
            unique case (r_state)
                FSM_IDLE: begin
                    if (!w_wr_left) begin
                        w_state_nxt = FSM_DONE;
                    end else if (!w_empty && available_write) begin
                        w_pop       = 1'b1;
                        w_state_nxt = FSM_WR_GAP;
                    end
                end
                FSM_WR_GAP: w_state_nxt = FSM_IDLE;
                FSM_DONE:   w_state_nxt = FSM_DONE;
                default:    w_state_nxt = FSM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cont_in     <= '0;
            r_cont_wr     <= '0;
            wr_request_en <= 1'b0;
            wr_data       <= '0;
            done          <= 1'b0;
        end else begin
            wr_request_en <= w_pop;
            if (w_push) r_cont_in <= r_cont_in + CNT_W'(1);
            if (w_pop) begin
                wr_data   <= w_head;
                r_cont_wr <= r_cont_wr + CNT_W'(1);
            end
            if (start && r_state == FSM_DONE) done <= 1'b1;
        end
    end

`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
    logic w_stall;

    assign w_stall = start & (r_state == FSM_IDLE) & ~w_empty & w_wr_left & ~available_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               stall_cycles <= '0;
        else if (w_stall && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_control_data_out.sv
// Directed testbench for control_data_out; written words are logged from
// wr_request_en strobes and compared against hand-derived sequences.
module tb_control_data_out;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  num_data_out;
    logic         data_in_valid;
    logic [511:0] data_in;
    logic         ready;
    logic         available_write;
    logic         wr_request_en;
    logic [511:0] wr_data;
    logic         done;
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    control_data_out #(
        .BUF_DEPTH (4),
        .DATA_W    (512)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_data_out    (num_data_out),
        .data_in_valid   (data_in_valid),
        .data_in         (data_in),
        .ready           (ready),
        .available_write (available_write),
        .wr_request_en   (wr_request_en),
        .wr_data         (wr_data),
        .done            (done)
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] base;
    int unsigned idx;
    int unsigned offer;

    function automatic logic [511:0] word(input int unsigned k);
        logic [31:0] v;
        v = base + 32'(k);
        return {16{v}};
    endfunction

    // Write log: every strobe seen at the falling edge, plus spacing check.
    int unsigned  cyc = 0;
    logic [511:0] q_wr [$];
    bit           have_last = 1'b0;
    int unsigned  last_wr_cyc = 0;
    int unsigned  gap_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_request_en === 1'b1) begin
            if (have_last && (cyc - last_wr_cyc) < 2) gap_err++;
            have_last   = 1'b1;
            last_wr_cyc = cyc;
            q_wr.push_back(wr_data);
        end
    end

    // One clock of handshake stimulus; returns 1ns after the rising edge.
    task automatic step();
        bit acc;
        data_in       = word(idx);
        data_in_valid = (idx < offer);
        #1;
        acc = data_in_valid && ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_rst_done"},  512'(done), 512'(0));
        check({tag, "_rst_wren"},  512'(wr_request_en), 512'(0));
        check({tag, "_rst_wdata"}, wr_data, 512'(0));
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
        check({tag, "_rst_stall"}, 512'(stall_cycles), 512'(0));
`endif
        start         = 1'b0;
        data_in_valid = 1'b0;
        #1;
        check({tag, "_rst_ready"}, 512'(ready), 512'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_wr.delete();
        have_last = 1'b0;
        gap_err   = 0;
        idx       = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input int unsigned n);
        check({tag, "_nwr"}, 512'(q_wr.size()), 512'(n));
        for (int unsigned i = 0; i < n; i++) begin
            if (i < q_wr.size()) check($sformatf("%s_wr%0d", tag, i), q_wr[i], word(i));
        end
        check({tag, "_gap"}, 512'(gap_err), 512'(0));
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        num_data_out    = '0;
        data_in_valid   = 1'b0;
        data_in         = '0;
        available_write = 1'b0;
        base            = 32'hA000_0000;
        idx             = 0;
        offer           = 0;
        #1;
        do_reset("init");

        // T1: three back-to-back words, writes at edges 2/4/6, done at edge 9
        base = 32'hA100_0000; num_data_out = 3; available_write = 1'b1; offer = 3;
        start = 1'b1;
        for (int unsigned n = 1; n <= 9; n++) begin
            step();
            check($sformatf("t1_wren_e%0d", n), 512'(wr_request_en),
                  512'((n == 2) || (n == 4) || (n == 6)));
            check($sformatf("t1_done_e%0d", n), 512'(done), 512'(n >= 9));
            if (n >= 3) check($sformatf("t1_ready_e%0d", n), 512'(ready), 512'(0));
        end
        check("t1_acc", 512'(idx), 512'(3));
        check_log("t1", 3);
        do_reset("t1");

        // T2: zero words requested
        base = 32'hA200_0000; num_data_out = 0; available_write = 1'b1; offer = 3;
        start = 1'b1;
        for (int unsigned n = 1; n <= 4; n++) begin
            step();
            check($sformatf("t2_ready_e%0d", n), 512'(ready), 512'(0));
            check($sformatf("t2_done_e%0d", n), 512'(done), 512'(n >= 2));
        end
        check("t2_acc", 512'(idx), 512'(0));
        check_log("t2", 0);
        do_reset("t2");

        // T3: output FIFO blocked, buffer fills at 4, then drain all 8
        base = 32'hA300_0000; num_data_out = 8; available_write = 1'b0; offer = 8;
        start = 1'b1;
        for (int unsigned n = 1; n <= 7; n++) step();
        check("t3_acc_full", 512'(idx), 512'(4));
        check("t3_ready_full", 512'(ready), 512'(0));
        check("t3_nwr_blocked", 512'(q_wr.size()), 512'(0));
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
        check("t3_stall", 512'(stall_cycles), 512'(6));
`endif
        available_write = 1'b1;
        for (int unsigned n = 1; n <= 40; n++) step();
        check("t3_acc", 512'(idx), 512'(8));
        check_log("t3", 8);
        check("t3_done", 512'(done), 512'(1));
`ifdef CONTROL_DATA_OUT_STALL_CNT_EN
        check("t3_stall_end", 512'(stall_cycles), 512'(6));
`endif
        do_reset("t3");

        // T4: core offers more words than requested
        base = 32'hA400_0000; num_data_out = 2; available_write = 1'b1; offer = 5;
        start = 1'b1;
        for (int unsigned n = 1; n <= 15; n++) step();
        check("t4_acc", 512'(idx), 512'(2));
        check("t4_ready", 512'(ready), 512'(0));
        check_log("t4", 2);
        check("t4_done", 512'(done), 512'(1));
        do_reset("t4");

        // T5: start dropped for 5 cycles mid-stream
        base = 32'hA500_0000; num_data_out = 6; available_write = 1'b1; offer = 6;
        start = 1'b1;
        for (int unsigned n = 1; n <= 4; n++) step();
        start = 1'b0;
        for (int unsigned n = 1; n <= 5; n++) begin
            step();
            check($sformatf("t5_pause_wren%0d", n), 512'(wr_request_en), 512'(0));
            check($sformatf("t5_pause_ready%0d", n), 512'(ready), 512'(0));
        end
        check("t5_pause_nwr", 512'(q_wr.size()), 512'(2));
        check("t5_pause_acc", 512'(idx), 512'(4));
        check("t5_pause_done", 512'(done), 512'(0));
        start = 1'b1;
        for (int unsigned n = 1; n <= 30; n++) step();
        check("t5_acc", 512'(idx), 512'(6));
        check_log("t5", 6);
        check("t5_done", 512'(done), 512'(1));
        do_reset("t5");

        // T6: reset with two words buffered, then a fresh single-word run
        base = 32'hA600_0000; num_data_out = 4; available_write = 1'b1; offer = 4;
        start = 1'b1;
        for (int unsigned n = 1; n <= 3; n++) step();
        check("t6_pre_nwr", 512'(q_wr.size()), 512'(1));
        check("t6_pre_wdata", wr_data, word(0));
        do_reset("t6");
        base = 32'hA700_0000; num_data_out = 1; available_write = 1'b1; offer = 1;
        start = 1'b1;
        for (int unsigned n = 1; n <= 10; n++) step();
        check_log("t6", 1);
        check("t6_done", 512'(done), 512'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
